// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, redirect
// request from execute, the decoupled (pc, instruction) stream to decode,
// and the sticky fetch-fault report.
// master = fetch unit side, slave = memory / decode / redirect side.
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output fault,
    output fault_pc
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  fault,
    input  fault_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch front end. Owns the program counter, reads a
// big-endian word from a combinational instruction memory and delivers
// (pc, instruction) pairs to decode through a 2-entry buffer.
// Optional macro IFU_FAULT_CHECK_EN: stop fetching on a misaligned or
// out-of-range fetch address and report it through fault/fault_pc until
// the next redirect or reset. Without it, fault/fault_pc stay 0 and the
// pc simply wraps modulo 2^32.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  if ((MEM_BYTES < 4) || ((MEM_BYTES % 4) != 0)) begin : g_bad_mem_size
    $error("MEM_BYTES must be a positive multiple of 4");
  end

  logic [31:0] fetch_pc_r;
  logic [31:0] head_pc_r;
  logic [31:0] head_instr_r;
  logic [31:0] tail_pc_r;
  logic [31:0] tail_instr_r;
  logic [1:0]  count_r;
  logic        fault_r;
  logic [31:0] fault_pc_r;

  logic        fault_cond_s;
  logic        valid_s;
  logic        pop_s;
  logic        push_s;

`ifdef IFU_FAULT_CHECK_EN
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  // Flag fetch addresses that are misaligned or beyond the last legal word.
  always_comb begin
    fault_cond_s = 1'b0;
    if ((fetch_pc_r[1:0] != 2'b00) || (fetch_pc_r > LAST_WORD)) begin
      fault_cond_s = 1'b1;
    end else begin
      fault_cond_s = 1'b0;
    end
  end
`else
  assign fault_cond_s = 1'b0;
`endif

  // A redirect hides the buffer immediately so no stale instruction leaks.
  assign valid_s = (count_r != 2'd0) & ~bus.redirect_valid;
  assign pop_s   = valid_s & bus.out_ready;
  assign push_s  = ~fault_r & ~bus.redirect_valid & ~fault_cond_s &
                   ((count_r != 2'd2) | pop_s);

  assign bus.imem_address    = fetch_pc_r;
  assign bus.out_valid       = valid_s;
  assign bus.out_pc          = head_pc_r;
  assign bus.out_instruction = head_instr_r;
  assign bus.fault           = fault_r;
  assign bus.fault_pc        = fault_pc_r;

  // Program counter, fault capture and 2-entry head/tail buffer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r   <= RESET_PC;
      count_r      <= 2'd0;
      fault_r      <= 1'b0;
      fault_pc_r   <= 32'h0000_0000;
      head_pc_r    <= 32'h0000_0000;
      head_instr_r <= 32'h0000_0000;
      tail_pc_r    <= 32'h0000_0000;
      tail_instr_r <= 32'h0000_0000;
    end else if (bus.redirect_valid) begin
      count_r    <= 2'd0;
      fetch_pc_r <= bus.redirect_target;
      fault_r    <= 1'b0;
    end else begin
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else if (fault_cond_s && !fault_r) begin
        fault_r    <= 1'b1;
        fault_pc_r <= fetch_pc_r;
      end

      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_r    <= fetch_pc_r;
            head_instr_r <= bus.imem_instruction;
          end else begin
            tail_pc_r    <= fetch_pc_r;
            tail_instr_r <= bus.imem_instruction;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          // With one entry left the head keeps its value as the held output.
          if (count_r == 2'd2) begin
            head_pc_r    <= tail_pc_r;
            head_instr_r <= tail_instr_r;
          end
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_pc_r    <= tail_pc_r;
            head_instr_r <= tail_instr_r;
            tail_pc_r    <= fetch_pc_r;
            tail_instr_r <= bus.imem_instruction;
          end else begin
            head_pc_r    <= fetch_pc_r;
            head_instr_r <= bus.imem_instruction;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
